pipe_ctrl: RTL
==============

// Module: pipe_ctrl
// PURPOSE
//  Pipeline control unit, consumer end of the EXU->CU/PC redirect interface.
//  - Takes the EXU branch decision (ex2cu_jump_en / jump addr) and a memory-bus hold request.
//  - Sequences the PC redirect, IF/ID and ID/EX flush bubbles, and pipeline hold with a bus ack.
//  - Sits between EXU, PC, the IF/ID and ID/EX registers, and the bus interface.
// PARAMETERS
//  FLUSH_CYCLES  1   bubbles injected per taken jump (>=1); counter width $clog2(FLUSH_CYCLES+1)
// PORTS
//  clk                 in   1   core clock, all state on rising edge
//  rst_n               in   1   asynchronous active-low reset
//  ex2cu_jump_en_i     in   1   EXU taken-branch strobe (combinational from EXU)
//  ex2cu_jump_addr_i   in   32  EXU branch target
//  bus2cu_hold_req_i   in   1   bus wait request, level, held until ack seen
//  cu2bus_hold_ack_o   out  1   pipeline frozen acknowledge
//  cu2pc_jump_en_o     out  1   PC load strobe
//  cu2pc_jump_addr_o   out  32  PC load value
//  cu2pc_hold_o        out  1   PC hold
//  cu2ifid_flush_o     out  1   IF/ID clear to NOP (0x00000013) next edge
//  cu2ifid_hold_o      out  1   IF/ID hold
//  cu2idex_flush_o     out  1   ID/EX clear to NOP next edge
//  cu2idex_hold_o      out  1   ID/EX hold
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, ack=0; all outputs 0, jump_addr=32'h0.
//  - FSM states: IDLE, FLUSH, HOLD.
//  - IDLE, jump_en=1:
//      - jump_en_o=1, jump_addr_o=ex2cu_jump_addr_i, both flushes=1, same cycle (combinational; 0-cycle latency).
//      - Redirect and bubble take effect at the next edge.
//      - If FLUSH_CYCLES>1: go FLUSH, cnt<=FLUSH_CYCLES-1. Else stay IDLE.
//  - IDLE, jump_en=0, hold_req=1: go HOLD.
//  - Jump and hold_req in the same IDLE cycle: jump wins; hold is serviced after the flush completes
//    (hold_req stays asserted by protocol).
//  - FLUSH:
//      - Both flushes=1, jump_en_o=0; ex2cu_jump_en_i ignored (EX holds a bubble).
//      - cnt decrements each cycle; at cnt==1 go HOLD if hold_req, else IDLE.
//  - HOLD:
//      - pc/ifid/idex holds=1, flushes=0, jump_en_o=0.
//      - ack registered: 1 from the 2nd HOLD cycle onward.
//      - ex2cu_jump_en_i ignored in HOLD (EX frozen, strobe persists); acted on in the first IDLE cycle after exit.
//      - hold_req=0 -> IDLE next edge, ack<=0 on the same edge.
//  - Holds and flushes are never asserted together; hold_o=0 in IDLE/FLUSH.
//  - jump_addr_o=32'h0 whenever jump_en_o=0.
//  - Asynchronous reset mid-FLUSH/HOLD: immediate return to reset values; pending flush discarded.
// CONFIGURATION
//  - PIPE_CTRL_PERF_EN defined: adds outputs cu_flush_cnt_o[31:0] and cu_stall_cnt_o[31:0].
//      - cu_flush_cnt_o: +1 per cycle any flush is asserted.
//      - cu_stall_cnt_o: +1 per HOLD cycle.
//      - Both wrap at 2^32, reset to 0.
//  - Undefined: ports and counters absent; core behaviour identical.
// TESTING
//  1. Reset asserted mid-HOLD -> all outputs 0 in the same cycle; IDLE after release.
//  2. FLUSH_CYCLES=1, jump_en=1, addr=0x80000040 -> jump_en_o=1, addr_o=0x80000040, both flushes=1
//     that cycle; all 0 the next cycle.
//  3. FLUSH_CYCLES=3, jump pulse -> flushes high exactly 3 cycles; second jump during FLUSH ignored
//     (jump_en_o stays 0).
//  4. hold_req high 5 cycles -> holds high 5 cycles, ack high cycles 2..5, all 0 the cycle after
//     req drops.
//  5. Jump and hold_req in the same cycle -> redirect + flush first, then HOLD the next cycle;
//     jump held during HOLD -> redirect in the first cycle after exit.
//  6. PIPE_CTRL_PERF_EN: run scenarios 3 and 4 -> flush_cnt=3, stall_cnt=5.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: EXU/bus -> control unit and control unit -> PC / pipeline
// register bundle.
//   master : producer side (EXU, bus), drives requests, observes control.
//   slave  : pipe_ctrl, consumes requests, drives redirect/flush/hold/ack.
interface pipe_ctrl_if;
  logic        ex2cu_jump_en_i;
  logic [31:0] ex2cu_jump_addr_i;
  logic        bus2cu_hold_req_i;
  logic        cu2bus_hold_ack_o;
  logic        cu2pc_jump_en_o;
  logic [31:0] cu2pc_jump_addr_o;
  logic        cu2pc_hold_o;
  logic        cu2ifid_flush_o;
  logic        cu2ifid_hold_o;
  logic        cu2idex_flush_o;
  logic        cu2idex_hold_o;

  modport master (
    output ex2cu_jump_en_i, ex2cu_jump_addr_i, bus2cu_hold_req_i,
    input  cu2bus_hold_ack_o, cu2pc_jump_en_o, cu2pc_jump_addr_o, cu2pc_hold_o,
           cu2ifid_flush_o, cu2ifid_hold_o, cu2idex_flush_o, cu2idex_hold_o
  );

  modport slave (
    input  ex2cu_jump_en_i, ex2cu_jump_addr_i, bus2cu_hold_req_i,
    output cu2bus_hold_ack_o, cu2pc_jump_en_o, cu2pc_jump_addr_o, cu2pc_hold_o,
           cu2ifid_flush_o, cu2ifid_hold_o, cu2idex_flush_o, cu2idex_hold_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit at the consumer end of the EXU redirect path.
// Turns a taken-branch strobe into a PC redirect plus FLUSH_CYCLES of IF/ID and
// ID/EX bubbles, and a bus hold request into a pipeline freeze with a
// registered acknowledge.
// Ports:
//   clk, rst_n : core clock, asynchronous active-low reset
//   cu_if      : pipe_ctrl_if.slave (jump/hold requests in; PC redirect,
//                flush, hold and bus ack out)
//   cu_flush_cnt_o / cu_stall_cnt_o : 32-bit event counters, present only when
//                PIPE_CTRL_PERF_EN is defined (flush cycles, HOLD cycles)
// Optional feature macro: PIPE_CTRL_PERF_EN
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  pipe_ctrl_if.slave    cu_if
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]   cu_flush_cnt_o,
  output logic [31:0]   cu_stall_cnt_o
`endif
);

  localparam int CNT_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_HOLD} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ack_q, ack_d;

  logic               jump_en;
  logic [31:0]        jump_addr;
  logic               flush;
  logic               hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ack_d     = 1'b0;
    jump_en   = 1'b0;
    jump_addr = 32'h0;
    flush     = 1'b0;
    hold      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A jump beats a simultaneous hold request; the bus keeps the request
        // up, so it is picked up once the bubbles are in.
        if (cu_if.ex2cu_jump_en_i) begin
          jump_en   = 1'b1;
          jump_addr = cu_if.ex2cu_jump_addr_i;
          flush     = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = S_FLUSH;
            cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
          end else if (cu_if.bus2cu_hold_req_i) begin
            state_d = S_HOLD;
          end
        end else if (cu_if.bus2cu_hold_req_i) begin
          state_d = S_HOLD;
        end
      end
      S_FLUSH: begin
        // EX holds a bubble here, so any strobe it shows is stale.
        flush = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = cu_if.bus2cu_hold_req_i ? S_HOLD : S_IDLE;
        end
      end
      S_HOLD: begin
        // EX is frozen; a pending jump strobe is taken in the first IDLE cycle.
        hold = 1'b1;
        if (cu_if.bus2cu_hold_req_i) ack_d   = 1'b1;
        else                         state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cu_if.cu2bus_hold_ack_o = ack_q;
  assign cu_if.cu2pc_jump_en_o   = jump_en;
  assign cu_if.cu2pc_jump_addr_o = jump_addr;
  assign cu_if.cu2pc_hold_o      = hold;
  assign cu_if.cu2ifid_flush_o   = flush;
  assign cu_if.cu2ifid_hold_o    = hold;
  assign cu_if.cu2idex_flush_o   = flush;
  assign cu_if.cu2idex_hold_o    = hold;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    flush_cnt_d = flush_cnt_q + {31'h0, flush};
    stall_cnt_d = stall_cnt_q + {31'h0, hold};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign cu_flush_cnt_o = flush_cnt_q;
  assign cu_stall_cnt_o = stall_cnt_q;
`endif

endmodule
